// File: rtl/calc_pkg.sv
// Shared key codes, display codes, result width and FSM encoding for the calculator controller.
// No logic; imported by calc_ctrl and bin2bcd_seq.
package calc_pkg;

  localparam int RES_W = 14;

  localparam logic [3:0] BLANK_CODE = 4'd15;
  localparam logic [3:0] MINUS_CODE = 4'd11;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_EQ    = 4'd13;
  localparam logic [3:0] KEY_CLR   = 4'd14;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CONV = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_PLUS) || (k == KEY_MINUS) || (k == KEY_MUL);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads the binary, W shift cycles later done pulses with bcd valid.
// Latency W+1 edges from start to done visible; start while running restarts; no backpressure.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int W = RES_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic [3:0][3:0] bcd,
  output logic            done
);

  logic [W-1:0] bin_sr;
  logic [4:0]   cnt;
  logic         run;
  logic [15:0]  adj;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    adj = '0;
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr <= '0;
      bcd    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_sr <= bin;
        bcd    <= '0;
        cnt    <= '0;
        run    <= 1'b1;
      end else if (run) begin
        bcd    <= 16'({adj, bin_sr[W-1]});
        bin_sr <= bin_sr << 1;
        cnt    <= cnt + 5'd1;
        if (cnt == 5'(W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: builds A/B from key events, computes A op B, shows sign+BCD result.
// '=' to result load is 16 edges; key_ready is low (keys dropped, not queued) while converting.
module calc_ctrl
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       busy,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] operator,
  output logic [3:0] digit4,
  output logic [3:0] digit5,
  output logic [3:0] digit6,
  output logic [3:0] digit7
);

  state_t           state;
  logic             key_acc;
  logic             conv_start;
  logic             conv_done;
  logic [RES_W-1:0] res_mag;
  logic [RES_W-1:0] res_mag_n;
  logic             res_neg;
  logic [3:0][3:0]  bcd;
  logic [3:0][3:0]  fmt;
  logic [6:0]       a_val;
  logic [6:0]       b_val;
  logic signed [14:0] a_s;
  logic signed [14:0] b_s;
  logic signed [14:0] res_s;

  assign key_acc = key_valid && key_ready;

  always_comb begin
    a_val = 7'(digit3) * 7'd10 + 7'(digit2);
    b_val = 7'(digit1) * 7'd10 + 7'(digit0);
    a_s   = signed'({8'd0, a_val});
    b_s   = signed'({8'd0, b_val});
    res_s = '0;
    case (operator)
      KEY_PLUS:  res_s = a_s + b_s;
      KEY_MINUS: res_s = a_s - b_s;
      KEY_MUL:   res_s = a_s * b_s;
      default:   res_s = '0;
    endcase
    res_mag_n = res_s[14] ? RES_W'(-res_s) : RES_W'(res_s);
  end

  // Leading zeros blank; a negative result is at most two digits so the sign sits in digit5 or digit6.
  always_comb begin
    fmt[3] = (bcd[3] == 4'd0) ? BLANK_CODE : bcd[3];
    fmt[2] = ({bcd[3], bcd[2]} == 8'd0) ? BLANK_CODE : bcd[2];
    fmt[1] = ({bcd[3], bcd[2], bcd[1]} == 12'd0) ? BLANK_CODE : bcd[1];
    fmt[0] = bcd[0];
    if (res_neg) begin
      if (bcd[1] != 4'd0) fmt[2] = MINUS_CODE;
      else                fmt[1] = MINUS_CODE;
    end
  end

  bin2bcd_seq #(.W(RES_W)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (res_mag),
    .bcd   (bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_A;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      conv_start <= 1'b0;
      res_mag    <= '0;
      res_neg    <= 1'b0;
      {digit3, digit2, digit1, digit0} <= '0;
      operator   <= BLANK_CODE;
      {digit7, digit6, digit5, digit4} <= {4{BLANK_CODE}};
    end else begin
      conv_start <= 1'b0;
      if (key_acc && key_code == KEY_CLR) begin
        state     <= S_A;
        key_ready <= 1'b1;
        busy      <= 1'b0;
        {digit3, digit2, digit1, digit0} <= '0;
        operator  <= BLANK_CODE;
        {digit7, digit6, digit5, digit4} <= {4{BLANK_CODE}};
      end else begin
        case (state)
          S_A: begin
            if (key_acc && is_digit(key_code)) begin
              digit3 <= digit2;
              digit2 <= key_code;
            end else if (key_acc && is_op(key_code)) begin
              operator <= key_code;
              state    <= S_B;
            end
          end
          S_B: begin
            if (key_acc && is_digit(key_code)) begin
              digit1 <= digit0;
              digit0 <= key_code;
            end else if (key_acc && is_op(key_code)) begin
              operator <= key_code;
            end else if (key_acc && key_code == KEY_EQ) begin
              res_mag    <= res_mag_n;
              res_neg    <= res_s[14];
              conv_start <= 1'b1;
              key_ready  <= 1'b0;
              state      <= S_CONV;
            end
          end
          S_CONV: begin
            if (conv_start) busy <= 1'b1;
            if (conv_done) begin
              {digit7, digit6, digit5, digit4} <= fmt;
              busy      <= 1'b0;
              key_ready <= 1'b1;
              state     <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (key_acc && is_digit(key_code)) begin
              {digit3, digit1, digit0} <= '0;
              digit2   <= key_code;
              operator <= BLANK_CODE;
              {digit7, digit6, digit5, digit4} <= {4{BLANK_CODE}};
              state    <= S_A;
            end
          end
          default: state <= S_A;
        endcase
      end
    end
  end

endmodule
